// File: rtl/dmem_if.sv
// CPU data-port bundle between the core (master) and the data-memory responder (slave).
// Handshake: the master holds write_enable/read_enable with address/write_data/xfer_size;
// a request is taken on a rising edge while busy is low, and done (with err) pulses once when it completes.
interface dmem_if;
  logic [63:0] address;
  logic        write_enable;
  logic        read_enable;
  logic [63:0] write_data;
  logic [3:0]  xfer_size;
  logic [63:0] read_data;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output address, write_enable, read_enable, write_data, xfer_size,
    input  read_data, busy, done, err
  );

  modport slave (
    input  address, write_enable, read_enable, write_data, xfer_size,
    output read_data, busy, done, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Byte-addressable big-endian data memory with configurable wait states,
// a busy/done handshake for stalling the core, and error responses for bad requests.
module dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic       clk,
  input  logic       reset,
  dmem_if.slave      bus,
  output logic [1:0] state_dbg
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  size_q;
  logic        store_q, err_q;

  logic [7:0]  mem [DEPTH];

  logic        req, bad, accept, commit;
  logic [63:0] c_addr, c_wdata, ld_val;
  logic [3:0]  c_size;
  logic        c_store;
  logic [7:0]  wr_byte [8];
  int          lane;

  assign req    = bus.write_enable | bus.read_enable;
  assign accept = (state_q == S_IDLE) && req;

  // Range check uses the full 64-bit address so high address bits never wrap into storage.
  assign bad = (bus.write_enable & bus.read_enable)
             | !(bus.xfer_size inside {4'd1, 4'd2, 4'd4, 4'd8})
             | ((bus.address[3:0] & (bus.xfer_size - 4'd1)) != 4'd0)
             | (({1'b0, bus.address} + 65'(bus.xfer_size)) > 65'(DEPTH));

  // With zero wait states the commit happens on the accept edge, straight from the bus.
  assign c_addr  = (state_q == S_IDLE) ? bus.address      : addr_q;
  assign c_wdata = (state_q == S_IDLE) ? bus.write_data   : wdata_q;
  assign c_size  = (state_q == S_IDLE) ? bus.xfer_size    : size_q;
  assign c_store = (state_q == S_IDLE) ? bus.write_enable : store_q;

  assign commit = ((state_q == S_IDLE) && req && !bad && (WAIT_STATES == 0))
               || ((state_q == S_WAIT) && (cnt_q == 4'd1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (bad || WAIT_STATES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ld_val = 64'd0;
    lane   = 0;
    for (int i = 0; i < 8; i++) begin
      lane       = (int'(c_size) - 1 - i) & 7;
      wr_byte[i] = c_wdata[8*lane +: 8];
      if (4'(i) < c_size) ld_val = {ld_val[55:0], mem[c_addr[AW-1:0] + AW'(i)]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      size_q  <= 4'd0;
      store_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= bus.address;
        wdata_q <= bus.write_data;
        size_q  <= bus.xfer_size;
        store_q <= bus.write_enable;
        err_q   <= bad;
      end
      if (commit && !c_store) rdata_q <= ld_val;
    end
  end

  // Storage is deliberately not reset; a reset only blocks a pending commit.
  always_ff @(posedge clk) begin
    if (!reset && commit && c_store) begin
      for (int i = 0; i < 8; i++) begin
        if (4'(i) < c_size) mem[c_addr[AW-1:0] + AW'(i)] <= wr_byte[i];
      end
    end
  end

  assign bus.read_data = rdata_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_RESP);
  assign bus.err       = (state_q == S_RESP) && err_q;
  assign state_dbg     = state_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized accesses checked against
// a byte-array reference model, and a zero-wait-state instance for back-to-back requests.
module tb_dmem_responder;
  localparam int DEPTH = 1024;
  localparam int WS    = 2;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] state_dbg, state_dbg0;

  dmem_if bus ();
  dmem_if bus0 ();

  dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS)) u_dut (
    .clk(clk), .reset(reset), .bus(bus), .state_dbg(state_dbg)
  );
  dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .state_dbg(state_dbg0)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]  mem_m [DEPTH];
  logic [63:0] rd_m = 64'd0;
  logic [63:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit req_bad(input logic we, input logic re, input logic [63:0] a, input int sz);
    if (we && re) return 1'b1;
    if (!(sz == 1 || sz == 2 || sz == 4 || sz == 8)) return 1'b1;
    if (a % sz != 0) return 1'b1;
    if ({1'b0, a} + 65'(sz) > 65'(DEPTH)) return 1'b1;
    return 1'b0;
  endfunction

  // One access on the wait-state instance; model updated, latency/err/read_data checked.
  task automatic access(input logic we, input logic re, input logic [63:0] a,
                        input int sz, input logic [63:0] wd);
    bit bad;
    int lat, exp_lat;
    logic [63:0] v;
    bad     = req_bad(we, re, a, sz);
    exp_lat = bad ? 1 : WS + 1;
    @(negedge clk);
    bus.address = a; bus.write_data = wd; bus.xfer_size = 4'(sz);
    bus.write_enable = we; bus.read_enable = re;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin bus.write_enable = 1'b0; bus.read_enable = 1'b0; end
      if (lat <= exp_lat) check("busy_inflight", 64'(bus.busy), 64'd1);
    end while (!bus.done && lat < 20);
    check("latency", 64'(lat), 64'(exp_lat));
    check("err", 64'(bus.err), 64'(bad));
    if (!bad) begin
      if (we) begin
        for (int i = 0; i < sz; i++) mem_m[a + i] = 8'(wd >> (8 * (sz - 1 - i)));
      end else begin
        v = 64'd0;
        for (int i = 0; i < sz; i++) v = v * 256 + 64'(mem_m[a + i]);
        rd_m = v;
      end
    end
    exp_q.push_back(rd_m);
    check("read_data", bus.read_data, exp_q.pop_front());
    @(negedge clk);
    check("idle_after_resp", {62'd0, bus.busy, bus.done}, 64'd0);
  endtask

  int sizes [6] = '{1, 2, 4, 8, 3, 8};
  int sz;
  logic [63:0] a, d;
  logic we, re;

  initial begin
    reset = 1'b1;
    bus.address = '0; bus.write_data = '0; bus.xfer_size = 4'd8;
    bus.write_enable = 1'b0; bus.read_enable = 1'b0;
    bus0.address = '0; bus0.write_data = '0; bus0.xfer_size = 4'd8;
    bus0.write_enable = 1'b0; bus0.read_enable = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_read_data", bus.read_data, 64'd0);
    check("rst_flags", {61'd0, bus.busy, bus.done, bus.err}, 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);

    // Reset together with a request: the request must not be taken.
    bus.read_enable = 1'b1;
    @(negedge clk);
    check("rst_beats_req", 64'(bus.busy), 64'd0);
    bus.read_enable = 1'b0;
    reset = 1'b0;

    for (int k = 0; k < DEPTH / 8; k++) access(1'b1, 1'b0, 64'(8 * k), 8, {$urandom, $urandom});

    access(1'b1, 1'b0, 64'd16, 8, 64'h0123456789ABCDEF);
    access(1'b0, 1'b1, 64'd16, 8, 64'd0);
    check("ld8_const", bus.read_data, 64'h0123456789ABCDEF);
    access(1'b0, 1'b1, 64'd16, 1, 64'd0);
    check("ld1_const", bus.read_data, 64'h01);
    access(1'b0, 1'b1, 64'd18, 2, 64'd0);
    check("ld2_const", bus.read_data, 64'h4567);
    access(1'b0, 1'b1, 64'd20, 4, 64'd0);
    check("ld4_const", bus.read_data, 64'h89ABCDEF);
    access(1'b1, 1'b0, 64'd22, 2, 64'hFFFFBEEF);
    access(1'b0, 1'b1, 64'd16, 8, 64'd0);
    check("st2_merge", bus.read_data, 64'h0123456789ABBEEF);

    access(1'b1, 1'b0, 64'd18, 4, 64'h11111111);
    access(1'b0, 1'b1, 64'd1024, 8, 64'd0);
    access(1'b1, 1'b0, 64'd0, 3, 64'h222222);
    access(1'b1, 1'b1, 64'd16, 8, 64'h3333333333333333);
    access(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 8, 64'd0);
    check("bad_keeps_rd", bus.read_data, 64'h0123456789ABBEEF);
    access(1'b0, 1'b1, 64'd16, 8, 64'd0);
    check("bad_keeps_mem", bus.read_data, 64'h0123456789ABBEEF);

    // Reset while a store waits: the store is dropped.
    access(1'b1, 1'b0, 64'd24, 8, 64'd0);
    @(negedge clk);
    bus.address = 64'd24; bus.write_data = 64'hAA; bus.xfer_size = 4'd1; bus.write_enable = 1'b1;
    @(negedge clk);
    bus.write_enable = 1'b0;
    check("in_wait", 64'(state_dbg), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rd_m = 64'd0;
    check("midrst_flags", {61'd0, bus.busy, bus.done, bus.err}, 64'd0);
    check("midrst_rd", bus.read_data, 64'd0);
    access(1'b0, 1'b1, 64'd24, 1, 64'd0);
    check("dropped_store", bus.read_data, 64'd0);

    for (int n = 0; n < 150; n++) begin
      sz = sizes[$urandom_range(0, 5)];
      case ($urandom_range(0, 9))
        0:       a = 64'($urandom_range(0, DEPTH + 16));
        1:       a = 64'(DEPTH - sz + 8 * $urandom_range(0, 1));
        default: a = 64'(sz * $urandom_range(0, DEPTH / sz - 1));
      endcase
      we = 1'($urandom_range(0, 1));
      re = ($urandom_range(0, 9) == 0) ? 1'b1 : !we;
      d  = {$urandom, $urandom};
      access(we, re, a, sz, d);
    end

    // Zero wait states with enables held: a new access every second cycle.
    @(negedge clk);
    bus0.address = 64'd40; bus0.xfer_size = 4'd8; bus0.write_data = 64'hFEDCBA9876543210;
    bus0.write_enable = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("held_st_done", 64'(bus0.done), 64'(k % 2));
      check("held_st_busy", 64'(bus0.busy), 64'(k % 2));
      check("held_st_err", 64'(bus0.err), 64'd0);
    end
    bus0.write_enable = 1'b0; bus0.read_enable = 1'b1; bus0.xfer_size = 4'd4; bus0.address = 64'd44;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("held_ld_done", 64'(bus0.done), 64'(k % 2));
      if (k % 2 == 1) check("held_ld_data", bus0.read_data, 64'h76543210);
    end
    bus0.read_enable = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
